motoro3_step_sequencer: RTL and testbench

Sequences the 3-phase motor PWM generator. It owns the per-step timebase: a step-position counter `m3cnt`, a 12-step commutation index `sgStep`, and the First/Last strobes that the PWM generator uses to clear, load and snapshot its accumulators. It sits between the register file (`m3r_*`) and `motoro3_pwm_generator`. It also handles run/stop, direction and round counting.

---
 rtl/motoro3_step_sequencer.sv | 101 ++++++++++
 tb/tb_motoro3_step_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/motoro3_step_sequencer.sv
// motoro3_step_sequencer: per-step timebase, 12-step commutation index and First/Last strobes for the 3-phase PWM generator
//   clk, rst            : system clock, asynchronous active-high reset
//   m3r_run             : run level; dropping it finishes the current step, then goes idle
//   m3r_dirRev          : step direction, taken at step boundaries
//   m3r_stepPeriod      : clocks per step, clamped to PERIOD_MIN and taken at step boundaries
//   sgStep, m3cnt       : commutation step and clock index within the step
//   m3cntFirst1/2       : m3cnt == 0 / 1 while active
//   m3cntLast2/1        : m3cnt == P-2 / P-1 while active
//   pwmActive1, busy    : high in RUN and STOP
//   roundCnt            : completed electrical rounds
module motoro3_step_sequencer #(
    parameter int STEP_NUM   = 12,
    parameter int CNT_W      = 25,
    parameter int PERIOD_MIN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m3r_run,
    input  logic             m3r_dirRev,
    input  logic [CNT_W-1:0] m3r_stepPeriod,
    output logic [3:0]       sgStep,
    output logic [CNT_W-1:0] m3cnt,
    output logic             m3cntFirst1,
    output logic             m3cntFirst2,
    output logic             m3cntLast2,
    output logic             m3cntLast1,
    output logic             pwmActive1,
    output logic [15:0]      roundCnt,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    localparam logic [CNT_W-1:0] PMIN  = CNT_W'(PERIOD_MIN);
    localparam logic [3:0]       SLAST = 4'(STEP_NUM - 1);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, per_in;
    logic [3:0]       step_q, step_d;
    logic [15:0]      round_q, round_d;
    logic             dir_q, dir_d, active, last, wrap;
    always_comb begin
        per_in  = m3r_stepPeriod < PMIN ? PMIN : m3r_stepPeriod;
        active  = state_q != IDLE;
        last    = active && cnt_q == per_q - CNT_W'(1);
        // wrap is judged in the direction latched for the step now ending
        wrap    = dir_q ? step_q == 4'd0 : step_q == SLAST;
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        dir_d   = dir_q;
        step_d  = step_q;
        round_d = round_q;
        if (state_q == IDLE) begin
            if (m3r_run) begin
                state_d = RUN;
                cnt_d   = '0;
                per_d   = per_in;
                dir_d   = m3r_dirRev;
                step_d  = m3r_dirRev ? SLAST : 4'd0;
            end
        end else if (!last) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = m3r_run ? RUN : STOP;
        end else if (state_q == STOP) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            // step end in RUN: a run drop here still lets the new step run fully
            state_d = m3r_run ? RUN : STOP;
            cnt_d   = '0;
            per_d   = per_in;
            dir_d   = m3r_dirRev;
            step_d  = dir_q ? (wrap ? SLAST : step_q - 4'd1) : (wrap ? 4'd0 : step_q + 4'd1);
            round_d = wrap ? round_q + 16'd1 : round_q;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= PMIN;
            dir_q   <= 1'b0;
            step_q  <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            round_q <= round_d;
        end
    end
    assign sgStep      = step_q;
    assign m3cnt       = cnt_q;
    assign roundCnt    = round_q;
    assign busy        = active;
    assign pwmActive1  = active;
    assign m3cntFirst1 = active && cnt_q == '0;
    assign m3cntFirst2 = active && cnt_q == CNT_W'(1);
    assign m3cntLast2  = active && cnt_q == per_q - CNT_W'(2);
    assign m3cntLast1  = last;
endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// tb_motoro3_step_sequencer: directed scoreboard bench for the motor step sequencer
module tb_motoro3_step_sequencer;
    typedef struct {
        logic        busy;
        logic [3:0]  step;
        logic [24:0] cnt;
        logic [3:0]  strb;
        logic [15:0] round;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst, run, dir;
    logic [24:0] per;
    logic [3:0]  sg_step;
    logic [24:0] cnt;
    logic        f1, f2, l2, l1, pwm_act, busy;
    logic [15:0] round_cnt;
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    always #5 clk = ~clk;
    motoro3_step_sequencer dut (
        .clk(clk), .rst(rst), .m3r_run(run), .m3r_dirRev(dir), .m3r_stepPeriod(per),
        .sgStep(sg_step), .m3cnt(cnt), .m3cntFirst1(f1), .m3cntFirst2(f2),
        .m3cntLast2(l2), .m3cntLast1(l1), .pwmActive1(pwm_act), .roundCnt(round_cnt), .busy(busy)
    );
    // expected strobes follow directly from the clock index and the step length
    function automatic exp_t mk(bit b, int s, int c, int p, int r);
        exp_t e;
        e.busy  = b;
        e.step  = 4'(s);
        e.cnt   = 25'(c);
        e.strb  = b ? {c == 0, c == 1, c == p - 2, c == p - 1} : 4'b0;
        e.round = 16'(r);
        return e;
    endfunction
    function automatic exp_t idle(int s, int r);
        return mk(0, s, 0, 4, r);
    endfunction
    task automatic chk(exp_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask
    task automatic run_step(int s, int p, int r);
        for (int c = 0; c < p; c++) chk(mk(1, s, c, p, r));
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (busy !== e.busy || pwm_act !== e.busy || sg_step !== e.step || cnt !== e.cnt ||
                {f1, f2, l2, l1} !== e.strb || round_cnt !== e.round) begin
                errors++;
                $display("FAIL sample %0d @%0t: got busy=%b act=%b step=%0d cnt=%0d strb=%b round=%0d, want busy=%b step=%0d cnt=%0d strb=%b round=%0d",
                         checks, $time, busy, pwm_act, sg_step, cnt, {f1, f2, l2, l1}, round_cnt,
                         e.busy, e.step, e.cnt, e.strb, e.round);
            end
        end
    end
    initial begin
        rst = 1'b1; run = 1'b0; dir = 1'b0; per = 25'd8;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk(idle(0, 0));
        run = 1'b1;
        chk(idle(0, 0));
        for (int s = 0; s < 12; s++) run_step(s, 8, 0);
        run_step(0, 8, 1);
        for (int c = 0; c < 8; c++) begin
            if (c == 2) run = 1'b0;
            chk(mk(1, 1, c, 8, 1));
        end
        chk(idle(1, 1));
        chk(idle(1, 1));
        run = 1'b1;
        chk(idle(1, 1));
        for (int c = 0; c < 8; c++) begin
            if (c == 2) run = 1'b0;
            if (c == 5) run = 1'b1;
            chk(mk(1, 0, c, 8, 1));
        end
        per = 25'd10;
        run_step(1, 8, 1);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) per = 25'd20;
            chk(mk(1, 2, c, 10, 1));
        end
        per = 25'd2;
        run_step(3, 20, 1);
        run_step(4, 4, 1);
        for (int c = 0; c < 4; c++) begin
            if (c == 0) run = 1'b0;
            chk(mk(1, 5, c, 4, 1));
        end
        chk(idle(5, 1));
        dir = 1'b1; per = 25'd4; run = 1'b1;
        chk(idle(5, 1));
        for (int s = 11; s >= 0; s--) run_step(s, 4, 1);
        per = 25'd8;
        run_step(11, 4, 2);
        for (int s = 10; s >= 8; s--) run_step(s, 8, 2);
        for (int c = 0; c < 5; c++) chk(mk(1, 7, c, 8, 2));
        rst = 1'b1; run = 1'b0;
        chk(idle(0, 0));
        chk(idle(0, 0));
        rst = 1'b0; dir = 1'b0; per = 25'd2;
        chk(idle(0, 0));
        run = 1'b1;
        chk(idle(0, 0));
        run_step(0, 4, 0);
        chk(mk(1, 1, 0, 4, 0));
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d samples left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
